// File: rtl/freq_meas_scheduler.sv
// freq_meas_scheduler: round-robin gated rising-edge counter shared across N_CH async inputs
module freq_meas_scheduler #(
  parameter int N_CH          = 4,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 32,
  localparam int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  signal_in,
  input  logic             enable,
  input  logic [N_CH-1:0]  ch_enable,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_count,
  output logic [CH_W-1:0]  result_ch,
  output logic             result_sat
);
  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX);
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_GATE, S_REPORT} state_t;
  state_t          r_state;
  logic [N_CH-1:0] r_sync1, r_sync2;
  logic            r_prev_sel, r_sat, r_valid;
  logic [CH_W-1:0] r_sel_ch, r_last_ch, w_next_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [TW-1:0]   r_timer;
  logic            w_found, w_sync_sel, w_edge;
  assign w_sync_sel   = r_sync2[r_sel_ch];
  assign w_edge       = w_sync_sel & ~r_prev_sel;
  assign busy         = (r_state != S_IDLE);
  assign result_valid = r_valid;
  assign result_count = r_cnt;
  assign result_ch    = r_sel_ch;
  assign result_sat   = r_sat;
  // Descending scan so the nearest enabled channel after r_last_ch wins
  always_comb begin
    w_found   = 1'b0;
    w_next_ch = r_last_ch;
    for (int i = N_CH; i >= 1; i--) begin
      if (ch_enable[CH_W'((int'(r_last_ch) + i) % N_CH)]) begin
        w_found   = 1'b1;
        w_next_ch = CH_W'((int'(r_last_ch) + i) % N_CH);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev_sel <= 1'b0;
      r_sel_ch   <= '0;
      r_last_ch  <= CH_W'(N_CH - 1);
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      r_valid    <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_sync1    <= signal_in;
      r_sync2    <= r_sync1;
      r_prev_sel <= w_sync_sel;
      case (r_state)
        S_IDLE: if (enable) r_state <= S_SELECT;
        S_SELECT: begin
          r_timer <= '0;
          if (enable && w_found) r_sel_ch <= w_next_ch;
          r_state <= (enable && w_found) ? S_SETTLE : S_IDLE;
        end
        S_SETTLE: begin
          r_cnt   <= '0;
          r_sat   <= 1'b0;
          r_timer <= r_timer + 1'b1;
          if (!enable) r_state <= S_IDLE;
          else if (r_timer == TW'(SETTLE_CYCLES - 1)) begin
            r_timer <= '0;
            r_state <= S_GATE;
          end
        end
        S_GATE: begin
          if (w_edge) begin
            if (&r_cnt) r_sat <= 1'b1;
            else r_cnt <= r_cnt + 1'b1;
          end
          r_timer <= r_timer + 1'b1;
          if (!enable) r_state <= S_IDLE;
          else if (r_timer == TW'(GATE_CYCLES - 1)) begin
            r_state <= S_REPORT;
            r_valid <= 1'b1;
          end
        end
        S_REPORT: if (r_valid && result_ready) begin
          r_valid   <= 1'b0;
          r_last_ch <= r_sel_ch;
          r_state   <= enable ? S_SELECT : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
